// File: rtl/console_io_if.sv
// CPU-side I/O port bus shared by the CPU core and the platform console responder.
// The CPU drives the port number and write strobe; the responder returns read
// data combinationally and raises the level interrupt request.
interface console_io_if;
    logic [8:0]  io_port;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [15:0] data_in;
    logic        irq;

    modport master (
        output io_port,
        output data_out,
        output data_out_valid,
        input  data_in,
        input  irq
    );

    modport slave (
        input  io_port,
        input  data_out,
        input  data_out_valid,
        output data_in,
        output irq
    );
endinterface

// File: rtl/console_io.sv
// Platform console responder for the CPU I/O port.
// Ports: 0 end-of-program, 2 stdin (RX FIFO), 3 stdout (TX FIFO),
// 4 interrupt status, 5 interrupt mask. Reads are side-effect free and
// combinational; writes take effect on the strobed clock edge.
// RX_DEPTH and TX_DEPTH must be powers of two and at least 2.
module console_io #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    console_io_if.slave cpu,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic [15:0] exit_code
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW + 1)'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);
    localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW + 1)'(1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);

    localparam logic [8:0] PORT_END    = 9'd0;
    localparam logic [8:0] PORT_STDIN  = 9'd2;
    localparam logic [8:0] PORT_STDOUT = 9'd3;
    localparam logic [8:0] PORT_ISTAT  = 9'd4;
    localparam logic [8:0] PORT_IMASK  = 9'd5;

    // RX FIFO state
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;

    // TX FIFO state
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_push;
    logic             tx_pop;

    // Interrupt and control state
    logic [1:0] mask;
    logic [1:0] pending;
    logic [1:0] status;
    logic       wr_end;
    logic       wr_stdin;
    logic       wr_stdout;
    logic       wr_imask;

    // Write decode: a write only exists in the strobed cycle.
    assign wr_end    = cpu.data_out_valid && (cpu.io_port == PORT_END);
    assign wr_stdin  = cpu.data_out_valid && (cpu.io_port == PORT_STDIN);
    assign wr_stdout = cpu.data_out_valid && (cpu.io_port == PORT_STDOUT);
    assign wr_imask  = cpu.data_out_valid && (cpu.io_port == PORT_IMASK);

    // Full/empty come from the registered counts, so push/pop decisions use
    // the pre-edge occupancy even when both happen in the same cycle.
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = wr_stdin && !rx_empty;

    assign tx_push  = wr_stdout && !tx_full;
    assign tx_pop   = tx_ready && !tx_empty;
    assign tx_valid = !tx_empty;
    // Storage is not reset; gate the head so the output is a clean 0 when empty.
    assign tx_byte  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

    // Interrupt status depends only on registered state, never on the CPU bus.
    assign pending = {!tx_full, !rx_empty};
    assign status  = pending & mask;
    assign cpu.irq = |status;

    // RX storage write; data array carries no reset.
    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_byte;
        end
    end

    // RX pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CNT_ONE;
                2'b01:   rx_count <= rx_count - RX_CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // TX storage write; data array carries no reset.
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= cpu.data_out[7:0];
        end
    end

    // TX pointers and occupancy; a push into a full FIFO is dropped even if it drains this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CNT_ONE;
                2'b01:   tx_count <= tx_count - TX_CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Sticky halt with the exit code of the first end-of-program write, plus the interrupt mask.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halted    <= 1'b0;
            exit_code <= 16'h0000;
            mask      <= 2'b00;
        end else begin
            if (wr_end && !halted) begin
                halted    <= 1'b1;
                exit_code <= cpu.data_out;
            end
            if (wr_imask) begin
                mask <= cpu.data_out[1:0];
            end
        end
    end

    // Combinational read mux; unmapped ports (including CPU-owned port 1) read 0.
    always_comb begin
        cpu.data_in = 16'h0000;
        case (cpu.io_port)
            PORT_STDIN:  cpu.data_in = rx_empty ? 16'h8000 : {8'h00, rx_mem[rx_rd_ptr]};
            PORT_STDOUT: cpu.data_in = {15'd0, !tx_full};
            PORT_ISTAT:  cpu.data_in = {14'd0, status};
            PORT_IMASK:  cpu.data_in = {14'd0, mask};
            default:     cpu.data_in = 16'h0000;
        endcase
    end

endmodule
